// File: rtl/register_file.sv
// Multi-entry register storage: one synchronous write port, two combinational
// read ports, synchronous bulk clear, optional write bypass and hardwired-zero entry.
module register_file #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned BYPASS   = 0,
  parameter int unsigned ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_b
);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic              wr_ok;
  logic [ADDR_W-1:0] raddr [2];
  logic [WIDTH-1:0]  rdata [2];

  // A write lands only on an in-range, non-hardwired entry with no clear or reset pending.
  assign wr_ok = we && !clr && !reset && (32'(waddr) < DEPTH) &&
                 !((ZERO_REG != 0) && (waddr == '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++)
        if (wr_ok && (waddr == ADDR_W'(i))) mem[i] <= wdata;
    end
  end

  assign raddr[0] = raddr_a;
  assign raddr[1] = raddr_b;

  // Address decode by comparison so out-of-range reads fall through to zero.
  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      rdata[p] = '0;
      for (int unsigned i = 0; i < DEPTH; i++)
        if (raddr[p] == ADDR_W'(i)) rdata[p] = mem[i];
      if ((ZERO_REG != 0) && (raddr[p] == '0)) rdata[p] = '0;
      if ((BYPASS != 0) && wr_ok && (raddr[p] == waddr)) rdata[p] = wdata;
      if (reset) rdata[p] = '0;
    end
  end

  assign rdata_a = rdata[0];
  assign rdata_b = rdata[1];

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: three configurations share one stimulus
// stream; expectations are queued by the driver and checked by a separate monitor.
module tb_register_file;

  logic       clk;
  logic       reset, clr, we;
  logic [2:0] waddr, raddr_a, raddr_b;
  logic [7:0] wdata;
  logic [7:0] ra0, rb0, ra1, rb1, ra2, rb2;

  // d0: plain 8x8; d1: bypass + zero entry; d2: 6 entries on a 3-bit address
  register_file #(.WIDTH(8), .DEPTH(8), .ADDR_W(3), .BYPASS(0), .ZERO_REG(0)) d0 (
    .clk(clk), .reset(reset), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(ra0), .raddr_b(raddr_b), .rdata_b(rb0));
  register_file #(.WIDTH(8), .DEPTH(8), .ADDR_W(3), .BYPASS(1), .ZERO_REG(1)) d1 (
    .clk(clk), .reset(reset), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(ra1), .raddr_b(raddr_b), .rdata_b(rb1));
  register_file #(.WIDTH(8), .DEPTH(6), .ADDR_W(3), .BYPASS(0), .ZERO_REG(0)) d2 (
    .clk(clk), .reset(reset), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(ra2), .raddr_b(raddr_b), .rdata_b(rb2));

  typedef struct {
    string      name;
    int         dut;
    bit         port;
    logic [7:0] exp;
  } item_t;

  item_t sb[$];
  event  sample_ev;
  int    compared   = 0;
  int    mismatched = 0;

  initial clk = 1'b0;
  always #20 clk = ~clk;

  function automatic logic [7:0] pick(input int dut, input bit port);
    case (dut)
      0:       return port ? rb0 : ra0;
      1:       return port ? rb1 : ra1;
      default: return port ? rb2 : ra2;
    endcase
  endfunction

  item_t      cur;
  logic [7:0] act;
  initial begin
    forever begin
      @(sample_ev);
      while (sb.size() > 0) begin
        cur = sb.pop_front();
        act = pick(cur.dut, cur.port);
        compared++;
        if (act !== cur.exp) begin
          mismatched++;
          $display("FAIL %s: dut%0d port %s got %02h expected %02h",
                   cur.name, cur.dut, cur.port ? "b" : "a", act, cur.exp);
        end
      end
    end
  end

  task automatic chk(input string name, input int dut, input bit port,
                     input logic [2:0] addr, input logic [7:0] exp);
    item_t it;
    if (port) raddr_b = addr; else raddr_a = addr;
    #1;
    it.name = name; it.dut = dut; it.port = port; it.exp = exp;
    sb.push_back(it);
    -> sample_ev;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; clr = 1'b0; we = 1'b0;
    waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
    @(negedge clk);

    chk("rst_a3", 0, 0, 3'd3, 8'h00);
    chk("rst_oor7", 2, 0, 3'd7, 8'h00);
    we = 1'b1; waddr = 3'd2; wdata = 8'h11;
    chk("rst_no_bypass", 1, 0, 3'd2, 8'h00);
    we = 1'b0;
    reset = 1'b0;
    tick();

    we = 1'b1; waddr = 3'd3; wdata = 8'hA5;
    chk("pre_a5", 0, 0, 3'd3, 8'h00);
    chk("byp_a5", 1, 0, 3'd3, 8'hA5);
    tick();
    we = 1'b0;
    chk("wr_a5_d0", 0, 0, 3'd3, 8'hA5);
    chk("wr_a5_d2", 2, 0, 3'd3, 8'hA5);
    #2 reset = 1'b1;
    chk("midrst_d0", 0, 0, 3'd3, 8'h00);
    chk("midrst_d1", 1, 0, 3'd3, 8'h00);
    #2 reset = 1'b0;
    tick();
    we = 1'b1; waddr = 3'd3; wdata = 8'h3C;
    chk("pre_3c", 0, 0, 3'd3, 8'h00);
    tick();
    we = 1'b0;
    chk("wr_3c", 0, 0, 3'd3, 8'h3C);

    we = 1'b1; waddr = 3'd5; wdata = 8'h7E;
    chk("lat_pre_a", 0, 0, 3'd5, 8'h00);
    chk("lat_pre_b", 0, 1, 3'd5, 8'h00);
    chk("lat_byp", 1, 0, 3'd5, 8'h7E);
    tick();
    we = 1'b0;
    chk("lat_post_a", 0, 0, 3'd5, 8'h7E);
    chk("lat_post_b", 0, 1, 3'd5, 8'h7E);
    chk("lat_d2_5", 2, 0, 3'd5, 8'h7E);

    we = 1'b1; waddr = 3'd2; wdata = 8'h11;
    chk("byp_a", 1, 0, 3'd2, 8'h11);
    chk("byp_b_other", 1, 1, 3'd4, 8'h00);
    chk("nobyp_a", 0, 0, 3'd2, 8'h00);
    tick();
    we = 1'b0;

    we = 1'b1; waddr = 3'd0; wdata = 8'h99;
    chk("zero_pre_byp", 1, 0, 3'd0, 8'h00);
    chk("zero_pre_d0", 0, 0, 3'd0, 8'h00);
    tick();
    we = 1'b0;
    chk("zero_post_d1", 1, 0, 3'd0, 8'h00);
    chk("zero_post_d0", 0, 0, 3'd0, 8'h99);
    chk("zero_post_d2", 2, 0, 3'd0, 8'h99);

    we = 1'b1; waddr = 3'd1; wdata = 8'h22;
    tick();
    waddr = 3'd6; wdata = 8'h66;
    tick();
    we = 1'b0;
    chk("pre_clr_1", 0, 0, 3'd1, 8'h22);
    chk("pre_clr_6", 0, 1, 3'd6, 8'h66);
    chk("oor6_d2", 2, 1, 3'd6, 8'h00);
    clr = 1'b1; we = 1'b1; waddr = 3'd1; wdata = 8'hFF;
    chk("clr_blocks_byp", 1, 0, 3'd1, 8'h22);
    tick();
    clr = 1'b0; we = 1'b0;
    for (int a = 0; a < 8; a++)
      chk($sformatf("clr_d0_%0d", a), 0, 0, 3'(a), 8'h00);

    we = 1'b1; waddr = 3'd7; wdata = 8'h55;
    tick();
    we = 1'b0;
    chk("oor_w7_d2", 2, 0, 3'd7, 8'h00);
    chk("w7_d0", 0, 1, 3'd7, 8'h55);
    for (int a = 0; a < 6; a++)
      chk($sformatf("oor_noalias_d2_%0d", a), 2, 0, 3'(a), 8'h00);
    we = 1'b1; waddr = 3'd5; wdata = 8'h55;
    tick();
    we = 1'b0;
    chk("w5_d2", 2, 0, 3'd5, 8'h55);

    #5;
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      mismatched += sb.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
